// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad debouncer: state encoding,
// the hex key map and the one-hot-low decoders used for latching and lookup.
package keypad_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 960000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } kp_state_e;

    // Nibble index = {row, col}; row0: 1 2 3 A, row1: 4 5 6 B, row2: 7 8 9 C, row3: E 0 F D
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic one_low(input logic [3:0] v);
        logic r;
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [3:0] row_v, input logic [3:0] col_v);
        logic [3:0] idx;
        idx = {low_idx(row_v), low_idx(col_v)};
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/debounce_timer.sv
// Saturating up-counter for the debounce interval; done flags the final
// count (CYCLES-1) so the FSM can act on the cycle that completes the interval.
module debounce_timer #(
    parameter int CYCLES = 960000
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == LAST);

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces one key of a scanned 4x4 keypad: freezes the scanner while a key
// is being qualified or held, and emits a single pulse with its hex code.
//
// state      | meaning
// IDLE       | waiting for exactly one key on a one-hot row
// DB_PRESS   | latched key must stay identical for the full interval
// PRESSED    | key accepted; only the latched column is watched
// DB_RELEASE | latched column high; must stay high for the full interval
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] col,
    input  logic [3:0] row,
    output logic       hold,
    output logic       key_valid,
    output logic [3:0] key_code
);

    kp_state_e  state_q, state_d;
    logic       hold_q, hold_d;
    logic       key_valid_q, key_valid_d;
    logic [3:0] key_code_q, key_code_d;
    logic [3:0] lat_row_q, lat_row_d;
    logic [3:0] lat_col_q, lat_col_d;
    logic       tmr_clear, tmr_enable, tmr_done;
    logic       match, released;

    assign match    = (col == lat_col_q) && (row == lat_row_q);
    // Any high bit at the latched (low) column position means that key let go.
    assign released = |(col & ~lat_col_q);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        lat_row_d   = lat_row_q;
        lat_col_d   = lat_col_q;
        tmr_clear   = 1'b1;
        tmr_enable  = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_low(col) && one_low(row)) begin
                    lat_row_d = row;
                    lat_col_d = col;
                    hold_d    = 1'b1;
                    state_d   = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (!match) begin
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end else if (tmr_done) begin
                    key_valid_d = 1'b1;
                    key_code_d  = key_lookup(lat_row_q, lat_col_q);
                    state_d     = PRESSED;
                end else begin
                    tmr_clear  = 1'b0;
                    tmr_enable = 1'b1;
                end
            end
            PRESSED: begin
                if (released) begin
                    state_d = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (!released) begin
                    state_d = PRESSED;
                end else if (tmr_done) begin
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmr_clear  = 1'b0;
                    tmr_enable = 1'b1;
                end
            end
            default: begin
                hold_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            lat_row_q   <= 4'hF;
            lat_col_q   <= 4'hF;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            lat_row_q   <= lat_row_d;
            lat_col_q   <= lat_col_d;
        end
    end

    debounce_timer #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_timer (
        .clk_sys(int_osc),
        .rst_b  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .done   (tmr_done)
    );

    assign hold      = hold_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Self-checking bench for keypad_debouncer with a short debounce interval.
module tb_keypad_debouncer;

    localparam int N = 4;

    logic       int_osc = 1'b0;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic       hold;
    logic       key_valid;
    logic [3:0] key_code;

    always #5 int_osc = ~int_osc;

    keypad_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .int_osc  (int_osc),
        .reset    (reset),
        .col      (col),
        .row      (row),
        .hold     (hold),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    int passed = 0;
    int total  = 0;

    int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    // Reference: a key is accepted after N+1 consecutive identical samples
    // (the latching sample plus N), and released after N+1 consecutive
    // samples with its column high.
    bit         m_busy, m_acc;
    logic [3:0] m_lr, m_lc, m_code;
    logic       m_valid;
    int         m_run;

    typedef struct {
        logic [3:0] col;
        logic [3:0] row;
        logic       hold;
        logic       valid;
        logic [3:0] code;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int low_pos(input logic [3:0] v);
        int n = 0;
        int p = -1;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) begin
                n++;
                p = i;
            end
        end
        return (n == 1) ? p : -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_run = 0; m_valid = 0; m_code = 4'h0;
        m_lr = 4'hF; m_lc = 4'hF;
    endtask

    task automatic model_edge();
        m_valid = 0;
        if (!m_busy) begin
            if (low_pos(col) >= 0 && low_pos(row) >= 0) begin
                m_busy = 1; m_acc = 0; m_lr = row; m_lc = col; m_run = 1;
            end
        end else if (!m_acc) begin
            if (col == m_lc && row == m_lr) begin
                m_run++;
                if (m_run == N + 1) begin
                    m_acc = 1; m_valid = 1; m_run = 0;
                    m_code = 4'(keymap[low_pos(m_lr)][low_pos(m_lc)]);
                end
            end else begin
                m_busy = 0;
            end
        end else begin
            if (col[low_pos(m_lc)]) begin
                m_run++;
                if (m_run == N + 1) begin
                    m_busy = 0; m_acc = 0; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic [3:0] c, input logic [3:0] r, input string tag);
        col = c;
        row = r;
        @(posedge int_osc);
        if (reset) model_edge();
        #1;
        check({tag, " hold"},  {3'b0, hold},      {3'b0, m_busy});
        check({tag, " valid"}, {3'b0, key_valid}, {3'b0, m_valid});
        check({tag, " code"},  key_code,          m_code);
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'hF;
        v[i] = 1'b0;
        return v;
    endfunction

    initial begin
        col = 4'hF;
        row = 4'hF;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge int_osc);
        #1;
        check("reset hold",  {3'b0, hold},      4'h0);
        check("reset valid", {3'b0, key_valid}, 4'h0);
        check("reset code",  key_code,          4'h0);
        reset = 1'b1;

        // Clean press of '2', hold, release, then invalid inputs in IDLE.
        for (int i = 0; i < 10; i++)
            tbl[i] = '{4'b1101, 4'b1110, 1'b1, (i == 4), (i >= 4) ? 4'h2 : 4'h0};
        for (int i = 10; i < 15; i++)
            tbl[i] = '{4'b1111, 4'b1110, (i < 14), 1'b0, 4'h2};
        tbl[15] = '{4'b1100, 4'b1110, 1'b0, 1'b0, 4'h2};
        tbl[16] = '{4'b1110, 4'b1010, 1'b0, 1'b0, 4'h2};
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].col, tbl[i].row, "tbl_model");
            check($sformatf("tbl%0d hold", i),  {3'b0, hold},      {3'b0, tbl[i].hold});
            check($sformatf("tbl%0d valid", i), {3'b0, key_valid}, {3'b0, tbl[i].valid});
            check($sformatf("tbl%0d code", i),  key_code,          tbl[i].code);
        end

        // Press bounce: two samples down, two up, repeated.
        for (int k = 0; k < 3; k++) begin
            step(4'b1101, 4'b1110, "bp");
            step(4'b1101, 4'b1110, "bp");
            check("bp hold_up", {3'b0, hold}, 4'h1);
            step(4'b1111, 4'b1110, "bp");
            check("bp hold_drop", {3'b0, hold}, 4'h0);
            step(4'b1111, 4'b1110, "bp");
            check("bp no_valid", {3'b0, key_valid}, 4'h0);
        end

        // Release bounce on '6' (row1, col2).
        for (int i = 0; i < 5; i++) step(4'b1011, 4'b1101, "br_press");
        check("br accept", {3'b0, key_valid}, 4'h1);
        check("br code", key_code, 4'h6);
        for (int i = 0; i < 2; i++) step(4'b1111, 4'b1101, "br_up");
        for (int i = 0; i < 3; i++) begin
            step(4'b1011, 4'b1101, "br_down");
            check("br no_second", {3'b0, key_valid}, 4'h0);
            check("br hold_kept", {3'b0, hold}, 4'h1);
        end
        for (int i = 0; i < 4; i++) step(4'b1111, 4'b1101, "br_rel");
        check("br hold_before_done", {3'b0, hold}, 4'h1);
        step(4'b1111, 4'b1101, "br_rel");
        check("br hold_released", {3'b0, hold}, 4'h0);

        // Asynchronous reset in DB_PRESS with the counter at 2.
        for (int i = 0; i < 3; i++) step(4'b1110, 4'b1101, "rst_press");
        reset = 1'b0;
        #1;
        model_reset();
        check("rst hold",  {3'b0, hold},      4'h0);
        check("rst valid", {3'b0, key_valid}, 4'h0);
        check("rst code",  key_code,          4'h0);
        step(4'b1111, 4'b1111, "rst_low");
        step(4'b1111, 4'b1111, "rst_low");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b1111, 4'b1111, "rst_idle");
        for (int i = 0; i < 4; i++) begin
            step(4'b1110, 4'b1101, "rst_new");
            check("rst no_early", {3'b0, key_valid}, 4'h0);
        end
        step(4'b1110, 4'b1101, "rst_new");
        check("rst new_valid", {3'b0, key_valid}, 4'h1);
        check("rst new_code", key_code, 4'h4);
        for (int i = 0; i < 5; i++) step(4'b1111, 4'b1101, "rst_rel");

        // Map sweep over all 16 keys.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 5; i++) step(oh(c), oh(r), "sweep");
                check($sformatf("map r%0d c%0d valid", r, c), {3'b0, key_valid}, 4'h1);
                check($sformatf("map r%0d c%0d code", r, c), key_code, 4'(keymap[r][c]));
                for (int i = 0; i < 5; i++) step(4'hF, oh(r), "sweep_rel");
                check($sformatf("map r%0d c%0d released", r, c), {3'b0, hold}, 4'h0);
            end
        end

        // Random keypad activity with bounces, stray columns and garbage.
        for (int s = 0; s < 250; s++) begin
            int mode;
            int kr;
            int kc;
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                    step(4'($urandom), 4'($urandom), "rnd_garbage");
            end else begin
                kr = $urandom_range(0, 3);
                kc = $urandom_range(0, 3);
                for (int i = 0; i < int'($urandom_range(1, 8)); i++)
                    step(($urandom_range(0, 5) == 0) ? 4'hF : oh(kc), oh(kr), "rnd_press");
                for (int i = 0; i < int'($urandom_range(1, 8)); i++)
                    step(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, oh(kr), "rnd_release");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
